// File: rtl/ad_valid_calib.sv
// Sweeps the 16 ad_valid_delay settings, scores each by raw byte bit errors and
// applies the setting with the fewest errors. All outputs are registered.
module ad_valid_calib #(
  parameter int unsigned SAMPLE_BYTES  = 1024,
  parameter int unsigned SETTLE_CYCLES = 64,
  parameter int unsigned ERR_LIMIT     = 16,
  parameter logic [3:0]  DELAY_INIT    = 4'd8
) (
  input  logic        clkcomm,
  input  logic        nRST,
  input  logic        start,
  input  logic        abort,
  input  logic        valid_raw,
  input  logic [7:0]  raw_send,
  input  logic [7:0]  raw_recv,
  output logic [3:0]  ad_valid_delay,
  output logic        comm_enable,
  output logic        busy,
  output logic        done,
  output logic [3:0]  best_delay,
  output logic [15:0] best_errors,
  output logic        fail
);

  typedef enum logic [2:0] {IDLE, SETTLE, MEASURE, EVAL, FINISH} state_t;

  localparam logic [15:0] SETTLE_LAST = 16'(SETTLE_CYCLES - 1);
  localparam logic [15:0] SAMPLE_LAST = 16'(SAMPLE_BYTES - 1);

  state_t      state_q;
  logic [15:0] cnt_q;
  logic [15:0] acc_q;
  logic [3:0]  delay_q, best_delay_q;
  logic [15:0] best_err_q;
  logic        busy_q, done_q, comm_q, fail_q;
  // Last completed-sweep results, restored if the sweep is aborted
  logic [3:0]  saved_delay_q, saved_best_delay_q;
  logic [15:0] saved_best_err_q;
  logic        saved_fail_q;

  logic [7:0]  diff_d;
  logic [3:0]  bit_err_d;
  logic [16:0] acc_sum_d;
  logic [15:0] acc_d;
  logic        better_d;
  logic [15:0] best_err_d;
  logic [3:0]  best_delay_d;

  always_comb begin
    diff_d    = raw_send ^ raw_recv;
    bit_err_d = '0;
    for (int i = 0; i < 8; i++) begin
      bit_err_d = bit_err_d + 4'(diff_d[i]);
    end
    acc_sum_d    = {1'b0, acc_q} + 17'(bit_err_d);
    acc_d        = acc_sum_d[16] ? 16'hFFFF : acc_sum_d[15:0];
    better_d     = acc_q < best_err_q;
    best_err_d   = better_d ? acc_q : best_err_q;
    best_delay_d = better_d ? delay_q : best_delay_q;
  end

  always_ff @(posedge clkcomm or negedge nRST) begin
    if (!nRST) begin
      state_q            <= IDLE;
      cnt_q              <= '0;
      acc_q              <= '0;
      delay_q            <= DELAY_INIT;
      best_delay_q       <= DELAY_INIT;
      best_err_q         <= 16'hFFFF;
      busy_q             <= 1'b0;
      done_q             <= 1'b0;
      comm_q             <= 1'b0;
      fail_q             <= 1'b0;
      saved_delay_q      <= DELAY_INIT;
      saved_best_delay_q <= DELAY_INIT;
      saved_best_err_q   <= 16'hFFFF;
      saved_fail_q       <= 1'b0;
    end else if (abort) begin
      if (state_q != IDLE && state_q != FINISH) begin
        delay_q      <= saved_delay_q;
        best_delay_q <= saved_best_delay_q;
        best_err_q   <= saved_best_err_q;
        fail_q       <= saved_fail_q;
      end
      state_q <= IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      comm_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            saved_delay_q      <= delay_q;
            saved_best_delay_q <= best_delay_q;
            saved_best_err_q   <= best_err_q;
            saved_fail_q       <= fail_q;
            state_q            <= SETTLE;
            busy_q             <= 1'b1;
            comm_q             <= 1'b1;
            delay_q            <= '0;
            acc_q              <= '0;
            cnt_q              <= '0;
            best_err_q         <= 16'hFFFF;
            best_delay_q       <= '0;
            fail_q             <= 1'b0;
          end
        end
        SETTLE: begin
          if (cnt_q == SETTLE_LAST) begin
            cnt_q   <= '0;
            state_q <= MEASURE;
          end else begin
            cnt_q <= cnt_q + 16'd1;
          end
        end
        MEASURE: begin
          if (valid_raw) begin
            acc_q <= acc_d;
            if (cnt_q == SAMPLE_LAST) begin
              cnt_q   <= '0;
              state_q <= EVAL;
              comm_q  <= 1'b0;
            end else begin
              cnt_q <= cnt_q + 16'd1;
            end
          end
        end
        EVAL: begin
          best_err_q   <= best_err_d;
          best_delay_q <= best_delay_d;
          if (delay_q == 4'd15) begin
            // Apply the winner and raise done as FINISH is entered
            state_q <= FINISH;
            delay_q <= best_delay_d;
            fail_q  <= 32'(best_err_d) > ERR_LIMIT;
            done_q  <= 1'b1;
          end else begin
            state_q <= SETTLE;
            delay_q <= delay_q + 4'd1;
            acc_q   <= '0;
            comm_q  <= 1'b1;
          end
        end
        FINISH: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign ad_valid_delay = delay_q;
  assign comm_enable    = comm_q;
  assign busy           = busy_q;
  assign done           = done_q;
  assign best_delay     = best_delay_q;
  assign best_errors    = best_err_q;
  assign fail           = fail_q;

endmodule

// File: tb/tb_ad_valid_calib.sv
// Directed bench: a loopback traffic model whose bit errors depend on the DUT
// delay setting, plus a second instance with a large sample count for saturation.
module tb_ad_valid_calib;

  localparam int SET = 3;
  localparam int SMP = 4;
  localparam int BIG = 8200;

  logic        clkcomm = 1'b0;
  logic        nRST = 1'b0;
  logic        start = 1'b0, abort = 1'b0, start2 = 1'b0, abort2 = 1'b0;
  logic        valid_raw = 1'b1;
  logic [7:0]  raw_send = '0, raw_recv = '0;
  logic [7:0]  raw_recv2;
  logic [3:0]  dly, bd, dly2, bd2;
  logic        comm, busy, done, fail, comm2, busy2, done2, fail2;
  logic [15:0] be, be2;

  int n_cmp = 0;
  int n_bad = 0;
  int mode = 0;
  bit gap_mode = 1'b0;
  int since = 0;
  logic [3:0] last_dly = 4'd8;
  bit last_busy = 1'b0;

  always #5 clkcomm = ~clkcomm;
  assign raw_recv2 = ~raw_send;

  ad_valid_calib #(.SAMPLE_BYTES(SMP), .SETTLE_CYCLES(SET), .ERR_LIMIT(16), .DELAY_INIT(4'd8)) dut (
    .clkcomm(clkcomm), .nRST(nRST), .start(start), .abort(abort), .valid_raw(valid_raw),
    .raw_send(raw_send), .raw_recv(raw_recv), .ad_valid_delay(dly), .comm_enable(comm),
    .busy(busy), .done(done), .best_delay(bd), .best_errors(be), .fail(fail));

  ad_valid_calib #(.SAMPLE_BYTES(BIG), .SETTLE_CYCLES(SET), .ERR_LIMIT(16), .DELAY_INIT(4'd8)) dut2 (
    .clkcomm(clkcomm), .nRST(nRST), .start(start2), .abort(abort2), .valid_raw(valid_raw),
    .raw_send(raw_send), .raw_recv(raw_recv2), .ad_valid_delay(dly2), .comm_enable(comm2),
    .busy(busy2), .done(done2), .best_delay(bd2), .best_errors(be2), .fail(fail2));

  // Link model: unstable for SET cycles after each delay change, then mode-dependent
  initial begin
    logic [7:0] mask;
    forever begin
      @(negedge clkcomm);
      if (dly !== last_dly || (busy && !last_busy)) begin
        last_dly = dly;
        since = 0;
      end else if (since < 100000) begin
        since++;
      end
      last_busy = busy;
      raw_send = 8'($urandom);
      if (since < SET)   mask = 8'hFF;
      else if (mode == 0) mask = (dly == 4'd5) ? 8'h00 : 8'hFF;
      else if (mode == 1) mask = (since == SET) ? 8'h07 : 8'h00;
      else                mask = 8'hFF;
      if (mode == 2) mask = 8'hFF;
      raw_recv  = raw_send ^ mask;
      valid_raw = gap_mode ? ~valid_raw : 1'b1;
    end
  end

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clkcomm);
    start = 1'b0;
  endtask

  // Runs until busy drops; counts busy cycles and done pulses
  task automatic wait_done(input int repulse_at, output int busy_cyc, output int done_cnt);
    busy_cyc = 0;
    done_cnt = 0;
    for (int i = 0; i < 4000; i++) begin
      if (!busy) break;
      busy_cyc++;
      if (done) done_cnt++;
      start = (i == repulse_at);
      @(negedge clkcomm);
    end
    start = 1'b0;
  endtask

  task automatic test_reset();
    nRST = 1'b0;
    repeat (3) @(negedge clkcomm);
    n_cmp++; if (dly !== 4'd8)      begin n_bad++; $display("FAIL rst_delay got %0d want 8", dly); end
    n_cmp++; if (comm !== 1'b0)     begin n_bad++; $display("FAIL rst_comm got %0b want 0", comm); end
    n_cmp++; if (busy !== 1'b0)     begin n_bad++; $display("FAIL rst_busy got %0b want 0", busy); end
    n_cmp++; if (done !== 1'b0)     begin n_bad++; $display("FAIL rst_done got %0b want 0", done); end
    n_cmp++; if (bd !== 4'd8)       begin n_bad++; $display("FAIL rst_best_delay got %0d want 8", bd); end
    n_cmp++; if (be !== 16'hFFFF)   begin n_bad++; $display("FAIL rst_best_errors got %0h want ffff", be); end
    n_cmp++; if (fail !== 1'b0)     begin n_bad++; $display("FAIL rst_fail got %0b want 0", fail); end
    nRST = 1'b1;
    repeat (2) @(negedge clkcomm);
    n_cmp++; if (busy !== 1'b0 || dly !== 4'd8) begin n_bad++; $display("FAIL rst_release busy=%0b delay=%0d want 0/8", busy, dly); end
  endtask

  task automatic test_loopback();
    int bc, dc;
    mode = 0;
    pulse_start();
    n_cmp++; if (busy !== 1'b1)   begin n_bad++; $display("FAIL start_busy got %0b want 1", busy); end
    n_cmp++; if (dly !== 4'd0)    begin n_bad++; $display("FAIL start_delay got %0d want 0", dly); end
    n_cmp++; if (comm !== 1'b1)   begin n_bad++; $display("FAIL start_comm got %0b want 1", comm); end
    n_cmp++; if (be !== 16'hFFFF || fail !== 1'b0) begin n_bad++; $display("FAIL start_best got %0h/%0b want ffff/0", be, fail); end
    wait_done(-1, bc, dc);
    n_cmp++; if (bc !== 129)      begin n_bad++; $display("FAIL loop_busy_cycles got %0d want 129", bc); end
    n_cmp++; if (dc !== 1)        begin n_bad++; $display("FAIL loop_done_pulses got %0d want 1", dc); end
    n_cmp++; if (bd !== 4'd5)     begin n_bad++; $display("FAIL loop_best_delay got %0d want 5", bd); end
    n_cmp++; if (be !== 16'd0)    begin n_bad++; $display("FAIL loop_best_errors got %0d want 0", be); end
    n_cmp++; if (fail !== 1'b0)   begin n_bad++; $display("FAIL loop_fail got %0b want 0", fail); end
    n_cmp++; if (dly !== 4'd5)    begin n_bad++; $display("FAIL loop_applied got %0d want 5", dly); end
    n_cmp++; if (comm !== 1'b0)   begin n_bad++; $display("FAIL loop_comm_idle got %0b want 0", comm); end
  endtask

  task automatic test_uniform();
    int bc, dc;
    mode = 1;
    pulse_start();
    wait_done(-1, bc, dc);
    n_cmp++; if (dc !== 1)        begin n_bad++; $display("FAIL uni_done got %0d want 1", dc); end
    n_cmp++; if (bd !== 4'd0)     begin n_bad++; $display("FAIL uni_best_delay got %0d want 0", bd); end
    n_cmp++; if (be !== 16'd3)    begin n_bad++; $display("FAIL uni_best_errors got %0d want 3", be); end
    n_cmp++; if (fail !== 1'b0)   begin n_bad++; $display("FAIL uni_fail got %0b want 0", fail); end
  endtask

  task automatic test_back_to_back();
    int bc, dc;
    mode = 1;
    pulse_start();
    wait_done(1, bc, dc);
    n_cmp++; if (bc !== 129)      begin n_bad++; $display("FAIL restart_busy_cycles got %0d want 129", bc); end
    n_cmp++; if (dc !== 1)        begin n_bad++; $display("FAIL restart_done got %0d want 1", dc); end
    repeat (3) @(negedge clkcomm);
    n_cmp++; if (busy !== 1'b0)   begin n_bad++; $display("FAIL restart_idle got %0b want 0", busy); end
  endtask

  task automatic test_all_inverted();
    int bc, dc;
    mode = 2;
    gap_mode = 1'b1;
    pulse_start();
    wait_done(-1, bc, dc);
    gap_mode = 1'b0;
    n_cmp++; if (dc !== 1)        begin n_bad++; $display("FAIL inv_done got %0d want 1", dc); end
    n_cmp++; if (bd !== 4'd0)     begin n_bad++; $display("FAIL inv_best_delay got %0d want 0", bd); end
    n_cmp++; if (be !== 16'd32)   begin n_bad++; $display("FAIL inv_best_errors got %0d want 32", be); end
    n_cmp++; if (fail !== 1'b1)   begin n_bad++; $display("FAIL inv_fail got %0b want 1", fail); end
  endtask

  task automatic test_abort();
    int bc, dc;
    bit found;
    mode = 0;
    pulse_start();
    wait_done(-1, bc, dc);
    pulse_start();
    found = 1'b0;
    for (int i = 0; i < 500; i++) begin
      if (dly == 4'd7 && since == SET + 1) begin found = 1'b1; break; end
      @(negedge clkcomm);
    end
    n_cmp++; if (!found) begin n_bad++; $display("FAIL abort_reach_d7 got timeout want delay 7 measure"); end
    abort = 1'b1;
    @(negedge clkcomm);
    abort = 1'b0;
    n_cmp++; if (busy !== 1'b0 || done !== 1'b0) begin n_bad++; $display("FAIL abort_busy_done got %0b/%0b want 0/0", busy, done); end
    n_cmp++; if (dly !== 4'd5)    begin n_bad++; $display("FAIL abort_delay got %0d want 5", dly); end
    n_cmp++; if (bd !== 4'd5 || be !== 16'd0 || fail !== 1'b0) begin n_bad++; $display("FAIL abort_results got %0d/%0d/%0b want 5/0/0", bd, be, fail); end
    n_cmp++; if (comm !== 1'b0)   begin n_bad++; $display("FAIL abort_comm got %0b want 0", comm); end
    dc = 0;
    for (int i = 0; i < 20; i++) begin
      if (done || busy) dc++;
      @(negedge clkcomm);
    end
    n_cmp++; if (dc !== 0)        begin n_bad++; $display("FAIL abort_quiet got %0d active cycles want 0", dc); end
    start = 1'b1;
    abort = 1'b1;
    @(negedge clkcomm);
    start = 1'b0;
    abort = 1'b0;
    n_cmp++; if (busy !== 1'b0 || dly !== 4'd5) begin n_bad++; $display("FAIL start_abort got busy=%0b delay=%0d want 0/5", busy, dly); end
  endtask

  task automatic test_reset_mid();
    int bc, dc;
    bit found;
    mode = 0;
    pulse_start();
    found = 1'b0;
    for (int i = 0; i < 500; i++) begin
      if (dly == 4'd9) begin found = 1'b1; break; end
      @(negedge clkcomm);
    end
    n_cmp++; if (!found) begin n_bad++; $display("FAIL rstmid_reach_d9 got timeout want delay 9"); end
    nRST = 1'b0;
    #1;
    n_cmp++; if (dly !== 4'd8 || busy !== 1'b0) begin n_bad++; $display("FAIL rstmid_state got delay=%0d busy=%0b want 8/0", dly, busy); end
    n_cmp++; if (bd !== 4'd8 || be !== 16'hFFFF) begin n_bad++; $display("FAIL rstmid_best got %0d/%0h want 8/ffff", bd, be); end
    @(negedge clkcomm);
    nRST = 1'b1;
    @(negedge clkcomm);
    pulse_start();
    n_cmp++; if (dly !== 4'd0 || busy !== 1'b1) begin n_bad++; $display("FAIL rstmid_restart got delay=%0d busy=%0b want 0/1", dly, busy); end
    wait_done(-1, bc, dc);
    n_cmp++; if (bc !== 129 || bd !== 4'd5 || dly !== 4'd5) begin n_bad++; $display("FAIL rstmid_sweep got cyc=%0d best=%0d delay=%0d want 129/5/5", bc, bd, dly); end
  endtask

  task automatic test_saturation();
    bit found;
    start2 = 1'b1;
    @(negedge clkcomm);
    start2 = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 9000; i++) begin
      if (dly2 == 4'd1) begin found = 1'b1; break; end
      @(negedge clkcomm);
    end
    n_cmp++; if (!found) begin n_bad++; $display("FAIL sat_reach_d1 got timeout want delay 1"); end
    n_cmp++; if (be2 !== 16'hFFFF) begin n_bad++; $display("FAIL sat_best_errors got %0h want ffff", be2); end
    n_cmp++; if (bd2 !== 4'd0 || busy2 !== 1'b1) begin n_bad++; $display("FAIL sat_best_delay got %0d busy=%0b want 0/1", bd2, busy2); end
    abort2 = 1'b1;
    @(negedge clkcomm);
    abort2 = 1'b0;
    n_cmp++; if (busy2 !== 1'b0 || dly2 !== 4'd8 || be2 !== 16'hFFFF || fail2 !== 1'b0) begin
      n_bad++; $display("FAIL sat_abort got busy=%0b delay=%0d err=%0h fail=%0b want 0/8/ffff/0", busy2, dly2, be2, fail2);
    end
  endtask

  initial begin
    test_reset();
    test_loopback();
    test_uniform();
    test_back_to_back();
    test_all_inverted();
    test_abort();
    test_reset_mid();
    test_saturation();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
